fifo_uart_tx: RTL and testbench

Drain-side consumer for the 8-bit, 64-entry synchronous FIFO. It pops one byte at a time through the FIFO read port (read enable, empty flag, registered data out with one-cycle latency) and serializes each byte onto a UART 8N1 line at a fixed baud set by a clock divider. It sits between the byte FIFO and the board's serial TX pin, so upstream logic only ever writes bytes into the FIFO.

---
 rtl/fifo_uart_tx_if.sv | 31 +++
 rtl/fifo_uart_tx.sv | 98 +++++++++
 tb/tb_fifo_uart_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO read port, the UART transmitter and the TX pin.
// The transmitter is the master: it strobes the FIFO read and drives the serial line.
interface fifo_uart_tx_if;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serializes each onto a UART 8N1 line.
// tx, fifo_rd_en and tx_done are registered so the pin and the FIFO strobe never glitch.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        rd_en_q, rd_en_d;
    logic        done_q, done_d;
    logic        baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE:  if (bus.enable && !bus.fifo_empty) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = bus.fifo_data;
                state_d = START;
            end
            START: if (baud_wrap) begin
                state_d   = DATA;
                bit_idx_d = 3'd0;
            end
            DATA: if (baud_wrap) begin
                if (bit_idx_q == 3'd7) begin
                    state_d   = STOP;
                    bit_idx_d = 3'd0;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: if (baud_wrap) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The counter only runs inside a bit period and restarts on any state or bit change.
        if (state_d != state_q || baud_wrap || state_q inside {IDLE, FETCH, LOAD})
            baud_d = 16'd0;
        else
            baud_d = baud_q + 16'd1;

        // Outputs are decoded from the next state so the registered versions line up with it.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.tx_done    = done_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a FIFO model feeds the DUT, a UART receiver monitor decodes tx
// and compares each frame against the byte sequence written into the FIFO.
module tb_fifo_uart_tx;

    localparam int CPB     = 4;
    localparam int FRAME   = 10 * CPB;
    localparam int MIN_GAP = FRAME + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [7:0] fifo_dout = 8'h00;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    int wr_total     = 0;
    int pop_total    = 0;
    int pop_on_empty = 0;

    logic [7:0] exp_q [$];
    int exp_rd   = 0;
    int exp_skip = 0;

    int rd_cnt = 0, done_cnt = 0, start_cnt = 0, cyc = 0;
    int last_start = 0, last_spacing = 0, rx_cnt = 0;
    bit rx_active = 1'b0, have_start = 1'b0, after_reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;

    assign bus.enable     = en;
    assign bus.fifo_data  = fifo_dout;
    assign bus.fifo_empty = (wr_total == pop_total);

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // FIFO read port: registered data, one-cycle latency after the strobe.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (wr_total == pop_total) begin
                pop_on_empty <= pop_on_empty + 1;
            end else begin
                fifo_dout <= mem[pop_total % 256];
                pop_total <= pop_total + 1;
            end
        end
    end

    // UART receiver: mid-bit sampling of start, 8 data bits LSB first, stop, then tx_done.
    always @(negedge clk) begin
        int k;
        cyc++;
        if (rst) begin
            rx_active   = 1'b0;
            after_reset = 1'b1;
        end else begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.tx_done)    done_cnt++;
            if (!rx_active) begin
                if (bus.tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    start_cnt++;
                    if (have_start && !after_reset) begin
                        last_spacing = cyc - last_start;
                        check_output("start_spacing_min", 32'(last_spacing >= MIN_GAP), 1);
                    end
                    have_start  = 1'b1;
                    after_reset = 1'b0;
                    last_start  = cyc;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2 && rx_cnt < FRAME) begin
                    k = rx_cnt / CPB;
                    if (k == 0) begin
                        check_output("start_bit", bus.tx, 0);
                    end else if (k <= 8) begin
                        rx_byte[k-1] = bus.tx;
                    end else begin
                        check_output("stop_bit", bus.tx, 1);
                        if (exp_rd + exp_skip >= exp_q.size()) begin
                            check_output("unexpected_frame", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                        end else begin
                            check_output("rx_byte", rx_byte, exp_q[exp_rd + exp_skip]);
                            exp_rd++;
                        end
                    end
                end else if (rx_cnt == FRAME) begin
                    check_output("tx_done_pulse", bus.tx_done, 1);
                    check_output("busy_in_done", bus.busy, 0);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        mem[wr_total % 256] = b;
        wr_total++;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check_output(name, 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_tx_low(input int budget, input string name);
        int n = 0;
        while (bus.tx !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check_output(name, 32'(bus.tx === 1'b0), 1);
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while (!(exp_rd + exp_skip == exp_q.size() && wr_total == pop_total && !bus.busy) && n < budget) begin
            tick(1);
            n++;
        end
        check_output("drain_timeout", 32'(n < budget), 1);
    endtask

    initial begin
        int rd0, d0, s0;
        int t = 0;
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "[TB] watchdog");
        t++;
    end

    initial begin
        int rd0, d0, s0;

        // Reset held with a byte already queued and enable high.
        en = 1'b1;
        apply_stimulus(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check_output("reset_tx", bus.tx, 1);
            check_output("reset_rd_en", bus.fifo_rd_en, 0);
            check_output("reset_busy", bus.busy, 0);
            check_output("reset_tx_done", bus.tx_done, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("rd_en_at_release", bus.fifo_rd_en, 0);
        tick(1);
        check_output("rd_en_latency", bus.fifo_rd_en, 1);
        check_output("busy_in_fetch", bus.busy, 1);
        tick(1);
        check_output("rd_en_single", bus.fifo_rd_en, 0);
        check_output("tx_high_in_load", bus.tx, 1);
        tick(1);
        check_output("start_bit_latency", bus.tx, 0);
        wait_done(1, 100, "frame_a5_done");
        check_output("a5_rd_pulses", rd_cnt, 1);
        check_output("a5_fifo_empty", wr_total - pop_total, 0);
        check_output("a5_busy_after", bus.busy, 0);

        // Back-to-back frames.
        rd0 = rd_cnt; d0 = done_cnt;
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        wait_done(d0 + 2, 150, "b2b_done");
        check_output("b2b_spacing", last_spacing, MIN_GAP);
        check_output("b2b_rd_pulses", rd_cnt - rd0, 2);
        check_output("b2b_done_pulses", done_cnt - d0, 2);

        // Empty FIFO with enable, then a byte with enable low.
        rd0 = rd_cnt; d0 = done_cnt; s0 = start_cnt;
        tick(200);
        check_output("empty_no_pop", rd_cnt - rd0, 0);
        check_output("empty_no_start", start_cnt - s0, 0);
        check_output("empty_tx_idle", bus.tx, 1);
        en = 1'b0;
        apply_stimulus(8'h3C);
        tick(100);
        check_output("disabled_no_pop", rd_cnt - rd0, 0);
        check_output("disabled_level", wr_total - pop_total, 1);
        check_output("disabled_busy", bus.busy, 0);
        en = 1'b1;
        wait_done(d0 + 1, 100, "frame_3c_done");
        check_output("3c_fifo_empty", wr_total - pop_total, 0);

        // Enable dropped during START with two bytes queued.
        rd0 = rd_cnt; d0 = done_cnt;
        apply_stimulus(8'h5A);
        apply_stimulus(8'h11);
        wait_tx_low(20, "5a_start_seen");
        en = 1'b0;
        wait_done(d0 + 1, 100, "frame_5a_done");
        tick(10);
        check_output("drop_level", wr_total - pop_total, 1);
        check_output("drop_busy", bus.busy, 0);
        check_output("drop_rd_pulses", rd_cnt - rd0, 1);
        check_output("drop_done_pulses", done_cnt - d0, 1);
        en = 1'b1;
        wait_done(d0 + 2, 100, "frame_11_done");

        // Reset during data bit 3 of 0x81; the popped byte is lost.
        d0 = done_cnt;
        apply_stimulus(8'h81);
        apply_stimulus(8'h42);
        wait_tx_low(20, "81_start_seen");
        tick(4 + 3 * CPB + 2);
        check_output("81_bit3_before_reset", bus.tx, 0);
        rst = 1'b1;
        #1;
        check_output("async_reset_tx", bus.tx, 1);
        check_output("async_reset_busy", bus.busy, 0);
        check_output("async_reset_rd_en", bus.fifo_rd_en, 0);
        exp_skip++;
        tick(2);
        rst = 1'b0;
        wait_done(d0 + 1, 150, "frame_42_done");
        check_output("42_fifo_empty", wr_total - pop_total, 0);

        // Random bytes with random enable and gaps.
        for (int i = 0; i < 20; i++) begin
            if (wr_total - pop_total < 60) apply_stimulus(8'($urandom_range(0, 255)));
            en = ($urandom_range(0, 3) != 0);
            tick($urandom_range(0, 60));
        end
        en = 1'b1;
        wait_drained(3000);
        check_output("all_frames_received", exp_rd + exp_skip, exp_q.size());
        check_output("final_fifo_empty", wr_total - pop_total, 0);
        check_output("pop_on_empty", pop_on_empty, 0);
        check_output("final_tx_idle", bus.tx, 1);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
